// File: rtl/uart_tx_queue_if.sv
// Bus-side handshake bundle for uart_tx_queue.
// Signals:
//   wr_en/wr_data  byte push from bus decode
//   flush/ovf_clr  discard queue / clear sticky overflow
//   full/empty/level/overflow  status for the status register
//   tx_we/tx_data  one-cycle write strobe and zero-extended byte to the uart
//   tx_wait        uart busy
// The master modport is the bus/uart side; the slave modport is the queue.
interface uart_tx_queue_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          ovf_clr;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx_we;
    logic [31:0]   tx_data;
    logic          tx_wait;

    modport master (
        output wr_en, wr_data, flush, ovf_clr, tx_wait,
        input  full, empty, level, overflow, tx_we, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, ovf_clr, tx_wait,
        output full, empty, level, overflow, tx_we, tx_data
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Transmit FIFO between bus decode and the uart. Queues pushed bytes and hands
// them to the uart one at a time with a one-cycle strobe, honouring tx_wait
// after a fixed holdoff.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  uart_tx_queue_if.slave (push, flush, status, uart strobe/data/wait)
module uart_tx_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_queue_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_tx_we;
    logic [31:0]   r_tx_data;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Status decoded from the registered level
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    // Flush dominates both push and pop; a push blocked by flush is not an overflow
    assign w_push = bus.wr_en && !w_full && !bus.flush;
    assign w_drop = bus.wr_en &&  w_full && !bus.flush;
    assign w_pop  = (r_state == IDLE) && !w_empty && !bus.tx_wait && !bus.flush;

    // Storage array, no reset needed: contents are only read behind the level count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, level and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_level <= r_level + LW'(w_push) - LW'(w_pop);
            end
            // Set has priority over clear
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM state register and registered uart outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tx_we   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Strobe is high exactly while the FSM sits in STROBE
            r_tx_we <= (w_state_nxt == STROBE);
            if (w_pop) begin
                r_tx_data <= {24'b0, r_mem[r_rd_ptr]};
            end
        end
    end

    // Next-state logic; HOLD ignores tx_wait so the uart has time to raise it
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pop) w_state_nxt = STROBE;
            end
            STROBE: begin
                w_cnt_nxt   = CW'(HOLDOFF - 1);
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            DRAIN: begin
                if (!bus.tx_wait) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
    assign bus.tx_we    = r_tx_we;
    assign bus.tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a scoreboard of accepted bytes is
// compared against every uart strobe, plus direct status checks.
module tb_uart_tx_queue;
    logic clk = 1'b0;
    logic rst;
    logic force_wait = 1'b0;
    logic model_wait = 1'b0;
    logic model_en   = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;
    int last_strobe = -100;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(16)) bus ();

    uart_tx_queue #(.DEPTH(16), .HOLDOFF(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_wait = force_wait | model_wait;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Move to the middle of the next cycle (negedge + 1)
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // One-cycle push; acceptance predicted from the scoreboard occupancy
    task automatic push(input logic [7:0] b);
        logic acc;
        acc = !bus.flush && (sb.size() < 16);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(posedge clk);
        if (acc) sb.push_back(b);
        @(negedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) cyc();
        check_eq("drain_done", 32'(sb.size()), 32'd0);
        repeat (15) cyc();
    endtask

    // Strobe monitor: every strobe must carry the oldest expected byte
    always @(negedge clk) begin
        logic [31:0] exp;
        cyc_n++;
        if (rst) begin
            last_strobe = -100;
        end else if (bus.tx_we) begin
            check_eq("wait_at_strobe", 32'(bus.tx_wait), 32'd0);
            if (last_strobe >= 0)
                check_eq("strobe_gap_ge5", 32'((cyc_n - last_strobe) >= 5), 32'd1);
            last_strobe = cyc_n;
            exp = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'hDEAD_BEEF;
            check_eq("tx_data", bus.tx_data, exp);
        end
    end

    // uart busy model: busy for 10 cycles starting one cycle after each strobe
    always begin
        @(negedge clk);
        if (model_en && bus.tx_we) begin
            @(posedge clk);
            #1 model_wait = 1'b1;
            repeat (10) @(posedge clk);
            #1 model_wait = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush   = 1'b0;
        bus.ovf_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        cyc();
        check_eq("rst_empty",    32'(bus.empty),    32'd1);
        check_eq("rst_full",     32'(bus.full),     32'd0);
        check_eq("rst_level",    32'(bus.level),    32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        check_eq("rst_tx_we",    32'(bus.tx_we),    32'd0);
        check_eq("rst_tx_data",  bus.tx_data,       32'd0);
        rst = 1'b0;
        cyc();

        // Single byte latency
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h41;
        @(posedge clk);
        sb.push_back(8'h41);
        @(negedge clk);
        #1;
        bus.wr_en = 1'b0;
        check_eq("lat_level1", 32'(bus.level), 32'd1);
        check_eq("lat_we_early", 32'(bus.tx_we), 32'd0);
        check_eq("lat_not_empty", 32'(bus.empty), 32'd0);
        cyc();
        check_eq("lat_we", 32'(bus.tx_we), 32'd1);
        check_eq("lat_data", bus.tx_data, 32'h0000_0041);
        check_eq("lat_level0", 32'(bus.level), 32'd0);
        check_eq("lat_empty", 32'(bus.empty), 32'd1);
        cyc();
        check_eq("we_one_cycle", 32'(bus.tx_we), 32'd0);
        check_eq("data_hold", bus.tx_data, 32'h0000_0041);
        wait_drain(50);

        // Fill, overflow, overflow set/clear priority, drain in order
        force_wait = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        check_eq("fill_full",  32'(bus.full),  32'd1);
        check_eq("fill_level", 32'(bus.level), 32'd16);
        push(8'h99);
        check_eq("ovf_set",   32'(bus.overflow), 32'd1);
        check_eq("ovf_level", 32'(bus.level),    32'd16);
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        check_eq("ovf_clr", 32'(bus.overflow), 32'd0);
        bus.ovf_clr = 1'b1;
        push(8'hAA);
        bus.ovf_clr = 1'b0;
        check_eq("ovf_set_wins", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        check_eq("ovf_clr2", 32'(bus.overflow), 32'd0);
        force_wait = 1'b0;
        wait_drain(300);
        check_eq("fill_drained", 32'(bus.empty), 32'd1);

        // uart busy after each strobe
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h51 + i));
        wait_drain(300);
        model_en = 1'b0;
        repeat (12) cyc();

        // Flush during HOLD of the first byte, with a simultaneous push
        for (int i = 0; i < 3; i++) push(8'(8'hA0 + i));
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        cyc();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        sb.delete();
        check_eq("flush_level", 32'(bus.level),    32'd0);
        check_eq("flush_empty", 32'(bus.empty),    32'd1);
        check_eq("flush_ovf",   32'(bus.overflow), 32'd0);
        repeat (20) cyc();
        check_eq("flush_stays_empty", 32'(bus.empty), 32'd1);
        check_eq("flush_last_data", bus.tx_data, 32'h0000_00A0);

        // Asynchronous reset mid-HOLD
        force_wait = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        check_eq("pre_rst_level", 32'(bus.level), 32'd5);
        force_wait = 1'b0;
        cyc();
        check_eq("pre_rst_we", 32'(bus.tx_we), 32'd1);
        cyc();
        check_eq("pre_rst_level4", 32'(bus.level), 32'd4);
        rst = 1'b1;
        #1;
        check_eq("arst_level",   32'(bus.level), 32'd0);
        check_eq("arst_empty",   32'(bus.empty), 32'd1);
        check_eq("arst_full",    32'(bus.full),  32'd0);
        check_eq("arst_tx_we",   32'(bus.tx_we), 32'd0);
        check_eq("arst_tx_data", bus.tx_data,    32'd0);
        sb.delete();
        cyc();
        rst = 1'b0;
        repeat (20) cyc();
        check_eq("post_rst_empty", 32'(bus.empty), 32'd1);
        check_eq("post_rst_level", 32'(bus.level), 32'd0);
        check_eq("post_rst_data",  bus.tx_data,    32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Transmit buffer between the SoC bus decode and the uart transmitter.
- Bus writes to the UART data register push bytes into a FIFO. The block feeds those bytes to the uart one at a time using the uart's one-cycle write strobe and its busy/wait signal.
- This means a bus write no longer has to stall or drop while the uart is busy.
- It also reports fill level and overflow, so the status register can expose them.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
HOLDOFF, 2, cycles to wait after the uart write strobe before sampling tx_wait; minimum 1.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  push request from bus decode; one byte per cycle
wr_data  in  8  byte to push
flush  in  1  discard all queued bytes
ovf_clr  in  1  clear the sticky overflow flag
full  out  1  FIFO holds DEPTH bytes
empty  out  1  FIFO holds 0 bytes
level  out  $clog2(DEPTH)+1  number of queued bytes, 0..DEPTH
overflow  out  1  sticky: a push was dropped
tx_we  out  1  one-cycle write strobe to the uart
tx_data  out  32  byte to the uart, zero-extended to 32 bits
tx_wait  in  1  uart busy; no strobe may be issued while high

Behaviour:
- Reset (asynchronous, while rst=1):
  - Pointers and level are 0; empty=1, full=0, overflow=0.
  - tx_we=0, tx_data=0, state IDLE, holdoff counter 0.
  - Reset mid-transfer abandons the in-flight byte.
- FIFO storage:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
  - level is a separate counter, updated as level + push - pop.
  - full = (level==DEPTH) and empty = (level==0); both are derived from the registered level.
- Push: accepted when wr_en=1, full=0 and flush=0.
  - wr_en=1 with full=1 drops the byte and sets overflow, even if a pop occurs in the same cycle.
- Overflow: ovf_clr=1 clears it; if a set and a clear occur in the same cycle, the set wins.
- Flush:
  - Resets pointers and level in one cycle, so empty=1 on the next cycle.
  - Flush wins over push and pop in the same cycle; the dropped push does not set overflow.
  - Flush does not abort a byte already popped (STROBE, HOLD or DRAIN state); that byte completes.
- State machine:
  - IDLE: if empty=0, tx_wait=0 and flush=0, pop the head byte, register tx_data={24'b0, byte}, go to STROBE. Otherwise stay.
  - STROBE: tx_we=1 for exactly this cycle; load the counter with HOLDOFF-1; go to HOLD.
  - HOLD: decrement the counter; at 0, go to DRAIN. tx_wait is ignored in this state.
  - DRAIN: when tx_wait=0, go to IDLE.
- tx_data holds its value from STROBE until the next pop.
- tx_we is registered and is 0 in every state except STROBE.
- Latency:
  - A push sampled at edge N into an empty queue, with tx_wait=0, gives tx_we=1 during cycle N+2.
  - Minimum spacing between strobes is HOLDOFF+3 cycles (IDLE, STROBE, HOLDOFF×HOLD, DRAIN); 5 with defaults.
- Simultaneous push and pop with full=0: level is unchanged and both pointers advance.
- If tx_wait stays high, the FSM remains in DRAIN or IDLE indefinitely; there is no timeout.

Test Plan:
- Reset, then push 0x41 with tx_wait=0: tx_we high exactly 2 cycles after the push, tx_data=0x00000041; level 1→0; empty returns to 1.
- Push 0x10..0x1F (16 bytes) back-to-back with tx_wait=1: full=1, level=16. Then push 0x99: overflow=1, level stays 16. Release tx_wait: 16 strobes in order 0x10..0x1F, no 0x99. Strobes are ≥5 cycles apart.
- Model tx_wait high for 10 cycles starting 1 cycle after each strobe: no strobe is issued while tx_wait=1, and every byte is delivered once.
- Queue 3 bytes, then assert flush during HOLD of the first byte: that byte's transfer completes, level=0 next cycle, and no further strobes occur. Flush and wr_en in the same cycle: byte dropped, overflow unchanged.
- Overflow set and ovf_clr on the same cycle: overflow=1. ovf_clr alone on the next cycle: overflow=0.
- Assert rst asynchronously mid-HOLD with 5 bytes queued: outputs return to reset values immediately without a clock edge; after release, no strobe occurs and empty=1.
